// File: rtl/readout_ctrl.sv
// Streams one event window from the circular sample RAM; first dout_valid 3 cycles after LOAD is entered.
// A 2-entry skid buffer absorbs dout_ready stalls at full throughput; dropping RO_ENABLE aborts the window.
module readout_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 12,
    parameter int PRE_TRIG = 256,
    parameter int RO_LEN   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RO_ENABLE,
    input  logic [ADDR_W-1:0] trig_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              RODONE_n
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_t;

    localparam logic [ADDR_W:0]   LEN_C  = (ADDR_W+1)'(RO_LEN);
    localparam logic [ADDR_W:0]   LAST_C = (ADDR_W+1)'(RO_LEN - 1);
    localparam logic [ADDR_W-1:0] PRE_C  = ADDR_W'(PRE_TRIG);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W:0]   r_issue_cnt;
    logic [ADDR_W:0]   r_xfer_cnt;
    logic              r_inflight;
    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_cnt;
    logic              w_run;
    logic              w_abort;
    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic [2:0]        w_occ;

    always_comb begin
        w_next  = r_state;
        w_run   = (r_state == S_STREAM) && RO_ENABLE;
        w_abort = !RO_ENABLE && ((r_state == S_LOAD) || (r_state == S_STREAM));
        w_pop   = (r_cnt != 2'd0) && dout_ready;
        w_push  = r_inflight && w_run;
        // A sample leaving this cycle frees its slot in time for the read issued now,
        // which is what sustains one sample per cycle with a 2-deep buffer.
        w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_issue = w_run && (r_issue_cnt < LEN_C) && (w_occ < 3'd2);
        case (r_state)
            S_IDLE:   if (RO_ENABLE) w_next = S_LOAD;
            S_LOAD:   w_next = RO_ENABLE ? S_STREAM : S_IDLE;
            S_STREAM: begin
                if (!RO_ENABLE)
                    w_next = S_IDLE;
                else if (w_pop && (r_xfer_cnt == LAST_C))
                    w_next = S_DONE;
            end
            S_DONE:   if (!RO_ENABLE) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    assign rd_en      = w_issue;
    assign rd_addr    = r_rd_addr;
    assign dout_valid = (r_cnt != 2'd0);
    assign dout       = r_mem[r_rd_ptr];
    assign dout_last  = dout_valid && (r_xfer_cnt == LAST_C);
    assign RODONE_n   = (r_state != S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rd_addr   <= '0;
            r_issue_cnt <= '0;
            r_xfer_cnt  <= '0;
            r_inflight  <= 1'b0;
            r_mem[0]    <= '0;
            r_mem[1]    <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_cnt       <= 2'd0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_issue;
            if (r_state == S_LOAD) begin
                r_rd_addr   <= trig_addr - PRE_C;
                r_issue_cnt <= '0;
                r_xfer_cnt  <= '0;
            end else if (w_issue) begin
                r_rd_addr   <= r_rd_addr + ADDR_W'(1);
                r_issue_cnt <= r_issue_cnt + (ADDR_W+1)'(1);
            end
            if (w_run && w_pop)
                r_xfer_cnt <= r_xfer_cnt + (ADDR_W+1)'(1);
            // On abort the buffer is emptied and the read still in flight is never written.
            if (w_abort) begin
                r_cnt    <= 2'd0;
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= rd_data;
                    r_wr_ptr        <= ~r_wr_ptr;
                end
                if (w_pop)
                    r_rd_ptr <= ~r_rd_ptr;
                r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

endmodule
